axi4_protocol_monitor: RTL and testbench
========================================

Name: axi4_protocol_monitor

Overview:
- Synthesizable AXI4 master-port protocol monitor, placed beside any AXI4 master in simulation and formal harnesses.
- Tracks up to MAX_OS outstanding read and write transactions in order.
- Checks ID ordering, burst beat counts, outstanding limits and write-data/response ordering.
- Raises sticky error flags as outputs instead of embedding fixed single-outstanding assumptions.

Parameters:
- MAX_OS, 4, maximum outstanding transactions per direction (1..16)
- ID_W, 6, width of arid/rid/awid/bid compared
- LEN_W, 8, width of arlen/awlen compared

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- axi_if  interface  -  axi_interface.formal modport; all signals observed, none driven
- err  output  10  sticky error flags, one bit per check (index list below)
- rd_os  output  $clog2(MAX_OS+1)  outstanding reads (AR accepted, RLAST not yet accepted)
- wr_os  output  $clog2(MAX_OS+1)  outstanding writes (AW accepted, B not yet accepted)
- wbeat_cnt  output  LEN_W  W beats accepted in the current write burst

Behaviour:
- Handshake acceptance: ar_acc = arvalid&arready; r_acc = rvalid&rready; likewise aw_acc, w_acc, b_acc.
- Reset: err=0, rd_os=0, wr_os=0, wbeat_cnt=0; all FIFOs empty; read beat counter 0. Reset mid-burst discards all tracking state.
- Flags are set one cycle after the offending handshake. Once set, they hold until rst.
- Read path, ar_fifo (depth MAX_OS, entries {arid,arlen}):
  - ar_acc pushes; rd_os increments.
  - Each r_acc increments rbeat. On rlast, ar_fifo pops, rbeat clears and rd_os decrements.
- Read checks:
  - err[0]: r_acc with ar_fifo empty. An AR accepted in the same cycle does not count as outstanding.
  - err[1]: r_acc with rid != head.arid.
  - err[2]: ar_acc while rd_os==MAX_OS and no pop this cycle. The push is dropped.
  - err[3]: rlast != (rbeat==head.arlen) on r_acc.
- Write path, two FIFOs:
  - aw_fifo (depth MAX_OS, entries {awid,awlen}) holds writes awaiting data.
  - b_fifo (depth MAX_OS, entries awid) holds writes with data complete awaiting B.
  - w_acc increments wbeat_cnt. On wlast, aw_fifo pops into b_fifo and wbeat_cnt clears.
  - W in the same cycle as AW with aw_fifo empty is legal and uses the incoming awid/awlen (bypass).
  - W with no pending and no concurrent AW flags err[7] and is otherwise ignored.
  - b_acc pops b_fifo; wr_os decrements.
  - wr_os = aw_fifo count + b_fifo count.
- Write checks:
  - err[4]: b_acc with b_fifo empty. A same-cycle wlast does not count.
  - err[5]: b_acc with bid != b_fifo head.
  - err[6]: aw_acc while wr_os==MAX_OS and no b_acc this cycle. The push is dropped.
  - err[7]: W without an AW, or wlast != (wbeat_cnt==head.awlen).
- Simultaneous push and pop on a full FIFO is legal: count is unchanged and no flag is raised.
- Pointer arithmetic wraps modulo MAX_OS. Counts saturate at MAX_OS and never underflow; an underflowing pop sets the flag and leaves state unchanged.

Optional Feature:
- AXI4_MON_STABILITY_EN defined: adds VALID/payload stability checks.
  - err[8]: any of arvalid/awvalid/wvalid dropped while low ready.
  - err[9]: AR/AW/W payload changed while valid&!ready.
  - Each err bit also drives a concurrent assert under disable iff (rst).
- Not defined: err[9:8] tied 0 and no assertions are emitted.

Decomposition:
- Shared package axi4_mon_pkg holds:
  - error index localparams (ERR_R_NO_OS..ERR_PAYLOAD_UNSTABLE);
  - ERR_W=10;
  - typedef rd_entry_t {id, len};
  - typedef wr_entry_t {id, len}.
- One sub-module, axi4_mon_fifo: parametrised (DEPTH, type T) synchronous FIFO.
  - Outputs: count, full, empty, head.
  - Supports same-cycle push/pop when full.
  - Instantiated three times: ar_fifo, aw_fifo, b_fifo.

Test Plan:
- MAX_OS=4: four ARs (ids 1,2,3,4, arlen 0), then R beats rid 1,2,3,4 with rlast -> rd_os 0→4→0, err=0.
- AR id 5 arlen 3, then R beats with rlast on beat 2 -> err[3] set the next cycle and sticky; rst clears it.
- Five ARs, no R -> fifth sets err[2], rd_os stays 4. AR and R-last in the same cycle at full -> no error.
- AW id 7 awlen 1 together with first W; second W with wlast; B bid 7 -> wbeat_cnt 1→0, wr_os 1→0, err=0.
- B before wlast -> err[4]. B bid 3 for pending id 7 -> err[5]. W with no AW -> err[7].
- Macro defined: arvalid deasserted before arready -> err[8]; araddr changed while stalled -> err[9]. Macro undefined -> both bits stay 0.

Source files
------------

// File: rtl/axi4_mon_pkg.sv
// Shared definitions for the AXI4 protocol monitor.
// Holds the error-flag bit indices, the error vector width and the FIFO
// entry types. Entry fields are sized for the widest supported
// configuration (ID up to 16 bits, LEN up to 8 bits); narrower IDs and
// lengths are zero-extended into them, so comparisons stay exact.
package axi4_mon_pkg;

   localparam int ERR_W                = 10;
   localparam int ERR_R_NO_OS          = 0;
   localparam int ERR_R_ID             = 1;
   localparam int ERR_AR_OVF           = 2;
   localparam int ERR_R_LAST           = 3;
   localparam int ERR_B_NO_OS          = 4;
   localparam int ERR_B_ID             = 5;
   localparam int ERR_AW_OVF           = 6;
   localparam int ERR_W_ORDER          = 7;
   localparam int ERR_VALID_DROP       = 8;
   localparam int ERR_PAYLOAD_UNSTABLE = 9;

   localparam int ID_MAX_W  = 16;
   localparam int LEN_MAX_W = 8;

   typedef logic [ID_MAX_W-1:0]  id_t;
   typedef logic [LEN_MAX_W-1:0] len_t;

   typedef struct packed {
      id_t  id;
      len_t len;
   } rd_entry_t;

   typedef struct packed {
      id_t  id;
      len_t len;
   } wr_entry_t;

endpackage

// File: rtl/axi_interface.sv
// AXI4 signal bundle observed by the protocol monitor.
// Only the address, ID, length, last and handshake signals plus the
// AR/AW address and W data payloads are carried.
// Modport formal: every signal is an input (pure observer).
interface axi_interface #(
   parameter int ID_W   = 6,
   parameter int LEN_W  = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              arvalid, arready;
   logic [ID_W-1:0]   arid;
   logic [LEN_W-1:0]  arlen;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid, rready, rlast;
   logic [ID_W-1:0]   rid;
   logic              awvalid, awready;
   logic [ID_W-1:0]   awid;
   logic [LEN_W-1:0]  awlen;
   logic [ADDR_W-1:0] awaddr;
   logic              wvalid, wready, wlast;
   logic [DATA_W-1:0] wdata;
   logic              bvalid, bready;
   logic [ID_W-1:0]   bid;

   modport formal (
      input arvalid, arready, arid, arlen, araddr,
      input rvalid, rready, rlast, rid,
      input awvalid, awready, awid, awlen, awaddr,
      input wvalid, wready, wlast, wdata,
      input bvalid, bready, bid
   );
endinterface

// File: rtl/axi4_mon_fifo.sv
// Small synchronous FIFO used for the monitor's in-order tracking queues.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push, din - write request and entry; dropped when full unless a pop
//               happens in the same cycle
//   pop       - read request; ignored when empty
//   head      - entry at the read pointer (valid when !empty)
//   count, full, empty - occupancy status
module axi4_mon_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  T              din,
   output T              head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A pop frees the slot the push needs, so push-at-full is legal then.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/axi4_protocol_monitor.sv
// AXI4 master-port protocol monitor with in-order tracking of up to
// MAX_OS outstanding reads and writes. Violations latch sticky flags.
// Optional macro AXI4_MON_STABILITY_EN adds VALID-drop and payload
// stability checks (err[8], err[9]) with matching concurrent assertions;
// without it those bits are tied low.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   axi_if    - observed AXI4 bus (formal modport, nothing driven)
//   err       - sticky error flags, indices in axi4_mon_pkg
//   rd_os     - outstanding reads (AR accepted, RLAST not yet accepted)
//   wr_os     - outstanding writes (AW accepted, B not yet accepted)
//   wbeat_cnt - W beats accepted in the current write burst
// ID_W must not exceed 16 and LEN_W must not exceed 8.
module axi4_protocol_monitor
   import axi4_mon_pkg::*;
#(
   parameter int MAX_OS = 4,
   parameter int ID_W   = 6,
   parameter int LEN_W  = 8,
   localparam int OSW   = $clog2(MAX_OS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   axi_interface.formal      axi_if,
   output logic [ERR_W-1:0]  err,
   output logic [OSW-1:0]    rd_os,
   output logic [OSW-1:0]    wr_os,
   output logic [LEN_W-1:0]  wbeat_cnt
);
   logic ar_acc, r_acc, aw_acc, w_acc, b_acc;
   assign ar_acc = axi_if.arvalid & axi_if.arready;
   assign r_acc  = axi_if.rvalid  & axi_if.rready;
   assign aw_acc = axi_if.awvalid & axi_if.awready;
   assign w_acc  = axi_if.wvalid  & axi_if.wready;
   assign b_acc  = axi_if.bvalid  & axi_if.bready;

   // ---------------- read path ----------------
   rd_entry_t        ar_din, ar_head;
   logic [OSW-1:0]   ar_count;
   logic             ar_full, ar_empty, ar_push, ar_pop, ar_ovf;
   logic [LEN_W-1:0] rbeat;

   assign ar_din = '{id: id_t'(axi_if.arid), len: len_t'(axi_if.arlen)};
   assign ar_pop = r_acc & axi_if.rlast & ~ar_empty;
   assign ar_ovf = ar_acc & ar_full & ~ar_pop;
   assign ar_push = ar_acc & ~ar_ovf;
   assign rd_os  = ar_count;

   axi4_mon_fifo #(.DEPTH(MAX_OS), .T(rd_entry_t)) ar_fifo (
      .clk(clk), .rst(rst), .push(ar_push), .pop(ar_pop), .din(ar_din),
      .head(ar_head), .count(ar_count), .full(ar_full), .empty(ar_empty)
   );

   always_ff @(posedge clk) begin
      if (rst)                    rbeat <= '0;
      else if (r_acc & ~ar_empty) rbeat <= axi_if.rlast ? '0 : rbeat + LEN_W'(1);
   end

   // ---------------- write path ----------------
   wr_entry_t        aw_din, aw_head;
   id_t              b_din, b_head;
   logic [OSW-1:0]   aw_count, b_count;
   logic             aw_full, aw_empty, b_full, b_empty;
   logic             aw_push, aw_pop, b_push, b_pop, aw_ovf, wr_full;
   logic             bypass, w_ok, w_done;
   len_t             w_len;

   assign aw_din  = '{id: id_t'(axi_if.awid), len: len_t'(axi_if.awlen)};
   assign wr_os   = aw_count + b_count;
   assign wr_full = (wr_os == OSW'(MAX_OS));
   assign b_pop   = b_acc & ~b_empty;
   assign aw_ovf  = aw_acc & wr_full & ~b_acc;
   // A W beat may ride on a same-cycle AW when nothing else is waiting.
   assign bypass  = aw_acc & aw_empty & ~aw_ovf;
   assign w_ok    = w_acc & (~aw_empty | bypass);
   assign w_done  = w_ok & axi_if.wlast;
   assign w_len   = aw_empty ? aw_din.len : aw_head.len;
   // A single-beat bypassed burst goes straight to b_fifo.
   assign aw_push = aw_acc & ~aw_ovf & ~(bypass & w_done);
   assign aw_pop  = w_done & ~aw_empty;
   assign b_push  = w_done;
   assign b_din   = aw_empty ? aw_din.id : aw_head.id;

   axi4_mon_fifo #(.DEPTH(MAX_OS), .T(wr_entry_t)) aw_fifo (
      .clk(clk), .rst(rst), .push(aw_push), .pop(aw_pop), .din(aw_din),
      .head(aw_head), .count(aw_count), .full(aw_full), .empty(aw_empty)
   );

   axi4_mon_fifo #(.DEPTH(MAX_OS), .T(id_t)) b_fifo (
      .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .din(b_din),
      .head(b_head), .count(b_count), .full(b_full), .empty(b_empty)
   );

   always_ff @(posedge clk) begin
      if (rst)       wbeat_cnt <= '0;
      else if (w_ok) wbeat_cnt <= axi_if.wlast ? '0 : wbeat_cnt + LEN_W'(1);
   end

   // ---------------- optional stability checks ----------------
`ifdef AXI4_MON_STABILITY_EN
   localparam int AR_PL_W = $bits(axi_if.arid) + $bits(axi_if.arlen) + $bits(axi_if.araddr);
   localparam int AW_PL_W = $bits(axi_if.awid) + $bits(axi_if.awlen) + $bits(axi_if.awaddr);
   localparam int W_PL_W  = $bits(axi_if.wdata) + 1;

   logic               ar_hold, aw_hold, w_hold;
   logic [AR_PL_W-1:0] ar_pl, ar_pl_q;
   logic [AW_PL_W-1:0] aw_pl, aw_pl_q;
   logic [W_PL_W-1:0]  w_pl, w_pl_q;
   logic               stab_drop, stab_change;

   assign ar_pl = {axi_if.arid, axi_if.arlen, axi_if.araddr};
   assign aw_pl = {axi_if.awid, axi_if.awlen, axi_if.awaddr};
   assign w_pl  = {axi_if.wdata, axi_if.wlast};

   always_ff @(posedge clk) begin
      if (rst) begin
         ar_hold <= 1'b0;
         aw_hold <= 1'b0;
         w_hold  <= 1'b0;
      end else begin
         ar_hold <= axi_if.arvalid & ~axi_if.arready;
         aw_hold <= axi_if.awvalid & ~axi_if.awready;
         w_hold  <= axi_if.wvalid  & ~axi_if.wready;
      end
      ar_pl_q <= ar_pl;
      aw_pl_q <= aw_pl;
      w_pl_q  <= w_pl;
   end

   assign stab_drop   = (ar_hold & ~axi_if.arvalid) | (aw_hold & ~axi_if.awvalid) |
                        (w_hold & ~axi_if.wvalid);
   assign stab_change = (ar_hold & axi_if.arvalid & (ar_pl != ar_pl_q)) |
                        (aw_hold & axi_if.awvalid & (aw_pl != aw_pl_q)) |
                        (w_hold  & axi_if.wvalid  & (w_pl  != w_pl_q));

   a_valid_stable:   assert property (@(posedge clk) disable iff (rst) !stab_drop);
   a_payload_stable: assert property (@(posedge clk) disable iff (rst) !stab_change);
`endif

   // ---------------- error flags ----------------
   logic [ERR_W-1:0] err_set;

   always_comb begin
      err_set = '0;
      err_set[ERR_R_NO_OS] = r_acc & ar_empty;
      err_set[ERR_R_ID]    = r_acc & ~ar_empty & (id_t'(axi_if.rid) != ar_head.id);
      err_set[ERR_AR_OVF]  = ar_ovf;
      err_set[ERR_R_LAST]  = r_acc & ~ar_empty &
                             (axi_if.rlast != (len_t'(rbeat) == ar_head.len));
      err_set[ERR_B_NO_OS] = b_acc & b_empty;
      err_set[ERR_B_ID]    = b_acc & ~b_empty & (id_t'(axi_if.bid) != b_head);
      err_set[ERR_AW_OVF]  = aw_ovf;
      err_set[ERR_W_ORDER] = w_acc & ((aw_empty & ~bypass) |
                             (axi_if.wlast != (len_t'(wbeat_cnt) == w_len)));
`ifdef AXI4_MON_STABILITY_EN
      err_set[ERR_VALID_DROP]       = stab_drop;
      err_set[ERR_PAYLOAD_UNSTABLE] = stab_change;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) err <= '0;
      else     err <= err | err_set;
   end
endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Directed bench for axi4_protocol_monitor (MAX_OS=4, ID_W=6, LEN_W=8).
// Each step drives one cycle of bus activity, queues the expected monitor
// state, then pops it and compares one time unit after the clock edge.
module tb_axi4_protocol_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] err;
   logic [2:0] rd_os, wr_os;
   logic [7:0] wbeat_cnt;

   always #5 clk = ~clk;

   axi_interface #(.ID_W(6), .LEN_W(8), .ADDR_W(32), .DATA_W(32)) bus ();

   axi4_protocol_monitor #(.MAX_OS(4), .ID_W(6), .LEN_W(8)) dut (
      .clk(clk), .rst(rst), .axi_if(bus),
      .err(err), .rd_os(rd_os), .wr_os(wr_os), .wbeat_cnt(wbeat_cnt)
   );

   typedef struct {
      string      tag;
      logic [9:0] err;
      logic [2:0] rd;
      logic [2:0] wr;
      logic [7:0] wb;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

`ifdef AXI4_MON_STABILITY_EN
   localparam logic [9:0] E_DROP = 10'h100;
   localparam logic [9:0] E_CHG  = 10'h200;
`else
   localparam logic [9:0] E_DROP = 10'h000;
   localparam logic [9:0] E_CHG  = 10'h000;
`endif

   task automatic idle();
      bus.arvalid = 1'b0; bus.arready = 1'b1; bus.arid = '0; bus.arlen = '0; bus.araddr = '0;
      bus.rvalid  = 1'b0; bus.rready  = 1'b1; bus.rid  = '0; bus.rlast = 1'b0;
      bus.awvalid = 1'b0; bus.awready = 1'b1; bus.awid = '0; bus.awlen = '0; bus.awaddr = '0;
      bus.wvalid  = 1'b0; bus.wready  = 1'b1; bus.wdata = '0; bus.wlast = 1'b0;
      bus.bvalid  = 1'b0; bus.bready  = 1'b1; bus.bid = '0;
   endtask

   task automatic ar(input int id, input int len);
      bus.arvalid = 1'b1; bus.arid = 6'(id); bus.arlen = 8'(len);
   endtask
   task automatic r(input int id, input logic last);
      bus.rvalid = 1'b1; bus.rid = 6'(id); bus.rlast = last;
   endtask
   task automatic aw(input int id, input int len);
      bus.awvalid = 1'b1; bus.awid = 6'(id); bus.awlen = 8'(len);
   endtask
   task automatic w(input logic last);
      bus.wvalid = 1'b1; bus.wlast = last; bus.wdata = 32'hA5A5_0000;
   endtask
   task automatic b(input int id);
      bus.bvalid = 1'b1; bus.bid = 6'(id);
   endtask

   task automatic step(input string tag, input logic [9:0] e_err,
                       input int e_rd, input int e_wr, input int e_wb);
      exp_t e;
      e.tag = tag; e.err = e_err; e.rd = 3'(e_rd); e.wr = 3'(e_wr); e.wb = 8'(e_wb);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (err === e.err) else begin
         errors++; $error("FAIL %s err got %h want %h", e.tag, err, e.err);
      end
      checks++;
      assert (rd_os === e.rd) else begin
         errors++; $error("FAIL %s rd_os got %0d want %0d", e.tag, rd_os, e.rd);
      end
      checks++;
      assert (wr_os === e.wr) else begin
         errors++; $error("FAIL %s wr_os got %0d want %0d", e.tag, wr_os, e.wr);
      end
      checks++;
      assert (wbeat_cnt === e.wb) else begin
         errors++; $error("FAIL %s wbeat_cnt got %0d want %0d", e.tag, wbeat_cnt, e.wb);
      end
      idle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step("reset", 10'h000, 0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step("reset_a", 10'h000, 0, 0, 0);
      step("reset_b", 10'h000, 0, 0, 0);
      rst = 1'b0;

      // four reads in flight, drained in order
      for (int i = 1; i <= 4; i++) begin ar(i, 0); step("ar_fill", 10'h000, i, 0, 0); end
      for (int i = 1; i <= 4; i++) begin r(i, 1'b1); step("r_drain", 10'h000, 4 - i, 0, 0); end

      // early RLAST on a 4-beat burst
      ar(5, 3);       step("ar_len3", 10'h000, 1, 0, 0);
      r(5, 1'b0);     step("r_beat0", 10'h000, 1, 0, 0);
      r(5, 1'b1);     step("r_early_last", 10'h008, 0, 0, 0);
      step("r_last_sticky", 10'h008, 0, 0, 0);
      do_reset();

      // overflow, push+pop at full, ordering after wrap
      for (int i = 1; i <= 4; i++) begin ar(i, 0); step("ar_fill2", 10'h000, i, 0, 0); end
      ar(5, 0);             step("ar_ovf", 10'h004, 4, 0, 0);
      ar(6, 0); r(1, 1'b1); step("ar_full_pushpop", 10'h004, 4, 0, 0);
      r(2, 1'b1);           step("r_wrap_2", 10'h004, 3, 0, 0);
      r(3, 1'b1);           step("r_wrap_3", 10'h004, 2, 0, 0);
      r(4, 1'b1);           step("r_wrap_4", 10'h004, 1, 0, 0);
      r(6, 1'b1);           step("r_wrap_6", 10'h004, 0, 0, 0);
      r(1, 1'b1);           step("r_no_os", 10'h005, 0, 0, 0);
      ar(9, 0);             step("ar_9", 10'h005, 1, 0, 0);
      r(8, 1'b1);           step("r_bad_id", 10'h007, 0, 0, 0);
      do_reset();

      // same-cycle AR and R with nothing outstanding
      ar(3, 0); r(3, 1'b1); step("r_with_new_ar", 10'h001, 1, 0, 0);
      do_reset();

      // legal write with AW/W bypass
      aw(7, 1); w(1'b0);    step("aw_w_bypass", 10'h000, 0, 1, 1);
      w(1'b1);              step("w_last", 10'h000, 0, 1, 0);
      b(7);                 step("b_ok", 10'h000, 0, 0, 0);
      aw(2, 0); w(1'b1);    step("bypass_single", 10'h000, 0, 1, 0);
      b(2);                 step("b_ok2", 10'h000, 0, 0, 0);

      // write errors
      aw(7, 1);             step("aw_7", 10'h000, 0, 1, 0);
      w(1'b0);              step("w_beat0", 10'h000, 0, 1, 1);
      b(7);                 step("b_early", 10'h010, 0, 1, 1);
      w(1'b1);              step("w_last2", 10'h010, 0, 1, 0);
      b(3);                 step("b_bad_id", 10'h030, 0, 0, 0);
      w(1'b1);              step("w_no_aw", 10'h0B0, 0, 0, 0);
      do_reset();

      // write outstanding limit
      for (int i = 1; i <= 4; i++) begin aw(i, 0); step("aw_fill", 10'h000, 0, i, 0); end
      aw(5, 0);             step("aw_ovf", 10'h040, 0, 4, 0);
      w(1'b1);              step("w_to_b", 10'h040, 0, 4, 0);
      aw(6, 0); b(1);       step("aw_full_b", 10'h040, 0, 4, 0);
      w(1'b0);              step("w_missing_last", 10'h0C0, 0, 4, 1);
      do_reset();

      // stability: VALID drop, then payload change while stalled
      bus.arvalid = 1'b1; bus.arready = 1'b0; bus.arid = 6'd1; bus.araddr = 32'h100;
      step("ar_stall", 10'h000, 0, 0, 0);
      step("ar_drop", E_DROP, 0, 0, 0);
      bus.arvalid = 1'b1; bus.arready = 1'b0; bus.arid = 6'd1; bus.araddr = 32'h100;
      step("ar_stall2", E_DROP, 0, 0, 0);
      bus.arvalid = 1'b1; bus.arready = 1'b0; bus.arid = 6'd1; bus.araddr = 32'h200;
      step("ar_unstable", E_DROP | E_CHG, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
